// File: rtl/ibis_video_timing_gen.sv
// Raster timing generator: divides aclk down to a pixel strobe and produces
// sync/blanking/ordinate outputs, with timings reloadable at frame boundaries.
module ibis_video_timing_gen #(
  parameter int CLK_DIV   = 5,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [63:0] cfg_h,
  input  logic [63:0] cfg_v,
  input  logic [1:0]  cfg_pol,
  output logic        cfg_err,
  output logic        pix_stb,
  output logic        hsync,
  output logic        vsync,
  output logic        hblankn,
  output logic        vblankn,
  output logic        de,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] ord_x,
  output logic [15:0] ord_y
);

  localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic [63:0] H_DEFAULT = {16'(H_BP), 16'(H_SYNC), 16'(H_FP), 16'(H_ACTIVE)};
  localparam logic [63:0] V_DEFAULT = {16'(V_BP), 16'(V_SYNC), 16'(V_FP), 16'(V_ACTIVE)};
  localparam logic [1:0]  P_DEFAULT = {VSYNC_POL, HSYNC_POL};

  function automatic logic [17:0] total_of(input logic [63:0] f);
    return {2'b0, f[15:0]} + {2'b0, f[31:16]} + {2'b0, f[47:32]} + {2'b0, f[63:48]};
  endfunction

  function automatic logic fields_ok(input logic [63:0] f);
    return (f[15:0] != 16'd0) && (f[31:16] != 16'd0) && (f[47:32] != 16'd0) &&
           (f[63:48] != 16'd0) && (total_of(f) <= 18'd65536);
  endfunction

  function automatic logic in_sync(input logic [15:0] pos, input logic [63:0] f);
    logic [17:0] start;
    logic [17:0] stop;
    start = {2'b0, f[15:0]} + {2'b0, f[31:16]};
    stop  = start + {2'b0, f[47:32]};
    return ({2'b0, pos} >= start) && ({2'b0, pos} < stop);
  endfunction

  logic [3:0]  div_reg;
  logic [15:0] x_reg, y_reg, x_next, y_next;
  logic [63:0] h_cfg_reg, v_cfg_reg, h_cfg_next, v_cfg_next;
  logic [1:0]  pol_reg, pol_next;
  logic [63:0] h_shadow_reg, v_shadow_reg;
  logic [1:0]  pol_shadow_reg;
  logic        pending_reg, err_reg;
  logic        hsync_reg, vsync_reg, hblankn_reg, vblankn_reg, line_start_reg, frame_start_reg;
  logic [17:0] h_total, v_total;
  logic        x_wrap, y_wrap, frame_wrap, transfer, cfg_legal;

  assign h_total    = total_of(h_cfg_reg);
  assign v_total    = total_of(v_cfg_reg);
  assign pix_stb    = enable && (div_reg == DIV_LAST);
  assign x_wrap     = ({2'b0, x_reg} == h_total - 18'd1);
  assign y_wrap     = ({2'b0, y_reg} == v_total - 18'd1);
  assign frame_wrap = pix_stb && x_wrap && y_wrap;
  assign transfer   = cfg_valid && !pending_reg;
  assign cfg_legal  = fields_ok(cfg_h) && fields_ok(cfg_v);

  always_comb begin
    x_next     = x_reg;
    y_next     = y_reg;
    h_cfg_next = h_cfg_reg;
    v_cfg_next = v_cfg_reg;
    pol_next   = pol_reg;
    if (pix_stb) begin
      if (x_wrap) begin
        x_next = 16'd0;
        y_next = y_wrap ? 16'd0 : 16'(y_reg + 16'd1);
      end else begin
        x_next = 16'(x_reg + 16'd1);
      end
    end
    // Shadow must have been captured before this edge, so a same-cycle offer waits a frame.
    if (frame_wrap && pending_reg) begin
      h_cfg_next = h_shadow_reg;
      v_cfg_next = v_shadow_reg;
      pol_next   = pol_shadow_reg;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      div_reg         <= 4'd0;
      x_reg           <= 16'd0;
      y_reg           <= 16'd0;
      h_cfg_reg       <= H_DEFAULT;
      v_cfg_reg       <= V_DEFAULT;
      pol_reg         <= P_DEFAULT;
      h_shadow_reg    <= H_DEFAULT;
      v_shadow_reg    <= V_DEFAULT;
      pol_shadow_reg  <= P_DEFAULT;
      pending_reg     <= 1'b0;
      err_reg         <= 1'b0;
      hsync_reg       <= ~HSYNC_POL;
      vsync_reg       <= ~VSYNC_POL;
      hblankn_reg     <= 1'b1;
      vblankn_reg     <= 1'b1;
      line_start_reg  <= 1'b1;
      frame_start_reg <= 1'b1;
    end else begin
      if (enable) div_reg <= (div_reg == DIV_LAST) ? 4'd0 : 4'(div_reg + 4'd1);
      x_reg     <= x_next;
      y_reg     <= y_next;
      h_cfg_reg <= h_cfg_next;
      v_cfg_reg <= v_cfg_next;
      pol_reg   <= pol_next;
      err_reg   <= transfer && !cfg_legal;
      if (transfer && cfg_legal) begin
        h_shadow_reg   <= cfg_h;
        v_shadow_reg   <= cfg_v;
        pol_shadow_reg <= cfg_pol;
        pending_reg    <= 1'b1;
      end else if (frame_wrap) begin
        pending_reg    <= 1'b0;
      end
      // Flags are decoded from the next position so they align with ord_x/ord_y.
      hsync_reg       <= in_sync(x_next, h_cfg_next) ? pol_next[0] : ~pol_next[0];
      vsync_reg       <= in_sync(y_next, v_cfg_next) ? pol_next[1] : ~pol_next[1];
      hblankn_reg     <= (x_next < h_cfg_next[15:0]);
      vblankn_reg     <= (y_next < v_cfg_next[15:0]);
      line_start_reg  <= (x_next == 16'd0);
      frame_start_reg <= (x_next == 16'd0) && (y_next == 16'd0);
    end
  end

  assign cfg_ready   = !pending_reg;
  assign cfg_err     = err_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign hblankn     = hblankn_reg;
  assign vblankn     = vblankn_reg;
  assign de          = hblankn_reg && vblankn_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign ord_x       = x_reg;
  assign ord_y       = y_reg;

endmodule

// File: tb/tb_ibis_video_timing_gen.sv
// Directed bench: default 800-pixel lines with a 10-line frame, then runtime
// reloads, rejection, enable freeze and reset with a pending config.
module tb_ibis_video_timing_gen;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [63:0] cfg_h = 64'd0;
  logic [63:0] cfg_v = 64'd0;
  logic [1:0]  cfg_pol = 2'b00;
  logic        cfg_ready, cfg_err, pix_stb, hsync, vsync, hblankn, vblankn, de;
  logic        line_start, frame_start;
  logic [15:0] ord_x, ord_y;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n = 0;
  int t0 = 0;
  int stb_cnt = 0;

  always #5 aclk = ~aclk;

  ibis_video_timing_gen #(
    .CLK_DIV(5), .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_h(cfg_h), .cfg_v(cfg_v),
    .cfg_pol(cfg_pol), .cfg_err(cfg_err), .pix_stb(pix_stb),
    .hsync(hsync), .vsync(vsync), .hblankn(hblankn), .vblankn(vblankn), .de(de),
    .line_start(line_start), .frame_start(frame_start), .ord_x(ord_x), .ord_y(ord_y)
  );

  task automatic step();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_pos(input int x, input int y, input int max_cyc, output int waited);
    waited = 0;
    while (!(ord_x == 16'(x) && ord_y == 16'(y)) && waited < max_cyc) begin
      step();
      waited++;
    end
    chk($sformatf("reach_%0d_%0d", x, y), {ord_y, ord_x}, {16'(y), 16'(x)});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_err"}, 32'(cfg_err), 32'd0);
    chk({tag, "_hblankn"}, 32'(hblankn), 32'd1);
    chk({tag, "_vblankn"}, 32'(vblankn), 32'd1);
    chk({tag, "_de"}, 32'(de), 32'd1);
    chk({tag, "_line_start"}, 32'(line_start), 32'd1);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd1);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_ord"}, {ord_y, ord_x}, 32'd0);
    chk({tag, "_pix_stb"}, 32'(pix_stb), 32'd0);
  endtask

  task automatic offer(input logic [63:0] h, input logic [63:0] v, input logic [1:0] p);
    cfg_h = h;
    cfg_v = v;
    cfg_pol = p;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    $display("cfg offer h=%h v=%h pol=%b -> ready=%b err=%b at x=%0d y=%0d",
             h, v, p, cfg_ready, cfg_err, ord_x, ord_y);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk_reset_state("reset");

    // Defaults: strobe on every 5th cycle
    aresetn = 1'b1;
    enable = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk($sformatf("pix_stb_%0d", i), 32'(pix_stb), 32'((i % 5) == 4));
    end
    chk("ord_x_after_10", 32'(ord_x), 32'd2);

    wait_pos(639, 0, 5000, n);
    chk("hblankn_639", 32'(hblankn), 32'd1);
    chk("de_639", 32'(de), 32'd1);
    wait_pos(640, 0, 50, n);
    chk("hblankn_640", 32'(hblankn), 32'd0);
    chk("de_640", 32'(de), 32'd0);
    chk("hsync_640", 32'(hsync), 32'd1);
    wait_pos(655, 0, 200, n);
    chk("hsync_655", 32'(hsync), 32'd1);
    wait_pos(656, 0, 50, n);
    chk("hsync_656", 32'(hsync), 32'd0);
    wait_pos(751, 0, 600, n);
    chk("hsync_751", 32'(hsync), 32'd0);
    wait_pos(752, 0, 50, n);
    chk("hsync_752", 32'(hsync), 32'd1);
    wait_pos(0, 1, 500, n);
    chk("line_start_y1", 32'(line_start), 32'd1);
    chk("frame_start_y1", 32'(frame_start), 32'd0);
    chk("hblankn_y1", 32'(hblankn), 32'd1);
    wait_pos(0, 2, 5000, n);
    chk("line_period", 32'(n), 32'd4000);

    // Freeze with the divider part-way through a pixel
    wait_pos(100, 2, 1000, n);
    step();
    step();
    enable = 1'b0;
    stb_cnt = 0;
    for (int i = 0; i < 37; i++) begin
      step();
      stb_cnt += int'(pix_stb);
    end
    chk("freeze_stb_count", 32'(stb_cnt), 32'd0);
    chk("freeze_ord_x", 32'(ord_x), 32'd100);
    chk("freeze_line_start", 32'(line_start), 32'd0);
    enable = 1'b1;
    chk("resume_stb_div2", 32'(pix_stb), 32'd0);
    step();
    chk("resume_stb_div3", 32'(pix_stb), 32'd0);
    step();
    chk("resume_stb_div4", 32'(pix_stb), 32'd1);
    chk("resume_x_hold", 32'(ord_x), 32'd100);
    step();
    chk("resume_x_adv", 32'(ord_x), 32'd101);

    // Rejected offer: sync field zero
    offer({16'd1, 16'd0, 16'd1, 16'd4}, {16'd1, 16'd1, 16'd1, 16'd3}, 2'b11);
    chk("reject_err", 32'(cfg_err), 32'd1);
    chk("reject_ready", 32'(cfg_ready), 32'd1);
    step();
    chk("reject_err_pulse", 32'(cfg_err), 32'd0);
    chk("reject_ready_hold", 32'(cfg_ready), 32'd1);

    // Legal offer mid-frame: held until the wrap
    offer({16'd1, 16'd2, 16'd1, 16'd4}, {16'd1, 16'd1, 16'd1, 16'd3}, 2'b11);
    chk("accept_ready", 32'(cfg_ready), 32'd0);
    chk("accept_err", 32'(cfg_err), 32'd0);

    wait_pos(0, 4, 20000, n);
    chk("vblankn_y4", 32'(vblankn), 32'd0);
    chk("de_y4", 32'(de), 32'd0);
    chk("vsync_y4", 32'(vsync), 32'd1);
    wait_pos(0, 6, 9000, n);
    chk("vsync_y6", 32'(vsync), 32'd0);
    wait_pos(0, 7, 5000, n);
    chk("vsync_y7", 32'(vsync), 32'd0);
    wait_pos(0, 8, 5000, n);
    chk("vsync_y8", 32'(vsync), 32'd1);
    chk("vblankn_y8", 32'(vblankn), 32'd0);
    wait_pos(799, 9, 9000, n);
    chk("pending_ready", 32'(cfg_ready), 32'd0);
    wait_pos(0, 0, 10, n);
    chk("wrap_frame_start", 32'(frame_start), 32'd1);
    chk("wrap_ready", 32'(cfg_ready), 32'd1);
    chk("wrap_hsync_newpol", 32'(hsync), 32'd0);
    chk("wrap_vsync_newpol", 32'(vsync), 32'd0);
    chk("wrap_de", 32'(de), 32'd1);

    // New timing: 8 x 6, both syncs positive
    wait_pos(4, 0, 100, n);
    chk("small_hblankn_x4", 32'(hblankn), 32'd0);
    chk("small_hsync_x4", 32'(hsync), 32'd0);
    wait_pos(5, 0, 10, n);
    chk("small_hsync_x5", 32'(hsync), 32'd1);
    wait_pos(6, 0, 10, n);
    chk("small_hsync_x6", 32'(hsync), 32'd1);
    wait_pos(7, 0, 10, n);
    chk("small_hsync_x7", 32'(hsync), 32'd0);
    wait_pos(0, 3, 200, n);
    chk("small_vblankn_y3", 32'(vblankn), 32'd0);
    chk("small_vsync_y3", 32'(vsync), 32'd0);
    wait_pos(0, 4, 60, n);
    chk("small_vsync_y4", 32'(vsync), 32'd1);
    wait_pos(0, 5, 60, n);
    chk("small_vsync_y5", 32'(vsync), 32'd0);
    wait_pos(0, 0, 100, n);
    t0 = cyc;
    repeat (5) step();
    wait_pos(0, 0, 400, n);
    chk("small_frame_period", 32'(cyc - t0), 32'd240);

    // Offer lands on the wrap edge itself: must wait one more frame
    wait_pos(7, 5, 300, n);
    repeat (4) step();
    chk("edge_wrap_stb", 32'(pix_stb), 32'd1);
    offer({16'd1, 16'd1, 16'd1, 16'd2}, {16'd1, 16'd1, 16'd1, 16'd1}, 2'b00);
    chk("edge_ord", {ord_y, ord_x}, 32'd0);
    chk("edge_ready", 32'(cfg_ready), 32'd0);
    chk("edge_hsync_oldpol", 32'(hsync), 32'd0);
    t0 = cyc;
    repeat (5) step();
    wait_pos(0, 0, 400, n);
    chk("edge_old_period", 32'(cyc - t0), 32'd240);
    chk("edge_applied_ready", 32'(cfg_ready), 32'd1);
    chk("edge_applied_hsync", 32'(hsync), 32'd1);
    chk("edge_applied_vsync", 32'(vsync), 32'd1);
    t0 = cyc;
    wait_pos(3, 0, 50, n);
    chk("tiny_hsync_x3", 32'(hsync), 32'd0);
    chk("tiny_hblankn_x3", 32'(hblankn), 32'd0);
    wait_pos(0, 0, 200, n);
    chk("tiny_frame_period", 32'(cyc - t0), 32'd100);

    // Reset with a pending config discards it
    wait_pos(2, 1, 100, n);
    offer({16'd1, 16'd2, 16'd1, 16'd4}, {16'd1, 16'd1, 16'd1, 16'd3}, 2'b11);
    chk("prereset_ready", 32'(cfg_ready), 32'd0);
    step();
    aresetn = 1'b0;
    step();
    chk_reset_state("midreset");
    aresetn = 1'b1;
    wait_pos(656, 0, 5000, n);
    chk("postreset_hsync_656", 32'(hsync), 32'd0);
    chk("postreset_hblankn_656", 32'(hblankn), 32'd0);
    chk("postreset_ready", 32'(cfg_ready), 32'd1);
    wait_pos(752, 0, 600, n);
    chk("postreset_hsync_752", 32'(hsync), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
